// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the watermark FIFO.
//   fifo_mode_t : read-side behaviour (registered read or first-word fall-through)
//   cnt_w()     : width needed to hold an occupancy of 0..depth
//   ptr_w()     : width needed to address depth entries
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clock        : write clock
//   write_enable : store write_data at write_addr on the rising edge
//   write_addr   : write location
//   write_data   : word to store
//   read_addr    : read location
//   read_data    : word at read_addr (combinational)
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_watermark.sv
// fifo_watermark: synchronous FIFO of arbitrary depth with watermark flags
// and sticky overflow/underflow error flags.
//   clock, resetn            : clock and asynchronous active-low reset
//   write_enable, data_in    : push request and push data
//   read_enable              : pop request
//   clear_errors             : clears overflow/underflow (a new error wins)
//   data_out                 : read data (registered in STD, head word in FWFT)
//   full, empty              : occupancy is DEPTH / zero
//   almost_full/almost_empty : occupancy >= AF_LEVEL / <= AE_LEVEL
//   overflow, underflow      : sticky rejected-push / rejected-pop flags
//   count                    : current occupancy
module fifo_watermark
  import fifo_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         DEPTH    = 4,
  parameter fifo_mode_t MODE     = FIFO_STD,
  parameter int         AF_LEVEL = DEPTH - 1,
  parameter int         AE_LEVEL = 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      write_enable,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      read_enable,
  input  logic                      clear_errors,
  output logic [WIDTH-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);

  if (WIDTH < 1) begin : g_chk_width
    $fatal(1, "fifo_watermark: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "fifo_watermark: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $fatal(1, "fifo_watermark: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $fatal(1, "fifo_watermark: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] dout_q;
  logic             wr_acc;
  logic             rd_acc;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // A pop needs data; a push into a full FIFO is allowed only when a pop
  // frees a slot in the same cycle. A pop on empty is never rescued by a
  // simultaneous push.
  assign rd_acc = read_enable & ~empty;
  assign wr_acc = write_enable & (~full | rd_acc);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock        (clock),
    .write_enable (wr_acc),
    .write_addr   (wr_ptr),
    .write_data   (data_in),
    .read_addr    (rd_ptr),
    .read_data    (head)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags come only from the registered count.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // Set has priority over clear so an error in the clearing cycle survives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write_enable & ~wr_acc) | (overflow  & ~clear_errors);
      underflow <= (read_enable  & ~rd_acc) | (underflow & ~clear_errors);
    end
  end

  // Captures the word leaving the FIFO. In STD mode this is the output
  // register; in FWFT mode it is the value held while the FIFO is empty.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= head;
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? dout_q : head;
  end else begin : g_std
    assign data_out = dout_q;
  end

endmodule

// File: doc/fifo_watermark.md
FIFO_WATERMARK -- requirements
Module: fifo_watermark

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning entry count (>=2, any integer, not limited to powers of two).
REQ-003 The module SHALL have parameter MODE, default FIFO_STD, meaning read mode: FIFO_STD (registered read) or FIFO_FWFT (first-word fall-through).
REQ-004 The module SHALL have parameter AF_LEVEL, default DEPTH-1, meaning almost_full threshold (1..DEPTH).
REQ-005 The module SHALL have parameter AE_LEVEL, default 1, meaning almost_empty threshold (0..DEPTH-1).
REQ-006 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have ports write_enable (in, 1), data_in (in, WIDTH), read_enable (in, 1), clear_errors (in, 1): push request, push data, pop request, sticky-flag clear.
REQ-009 The module SHALL have ports data_out (out, WIDTH), full, empty, almost_full, almost_empty, overflow, underflow (out, 1 each) and count (out, $clog2(DEPTH+1)).

Function
REQ-010 A write SHALL be accepted when write_enable=1 and (!full or an accepted read occurs in the same cycle).
REQ-011 A read SHALL be accepted when read_enable=1 and !empty; a read on empty SHALL be rejected even when a write occurs in the same cycle.
REQ-012 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-013 count SHALL increment on an accepted write only, decrement on an accepted read only, and stay unchanged when both or neither occur.
REQ-014 full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL); all derived from registered count, no combinational input-to-flag paths.
REQ-015 In FIFO_STD, an accepted read SHALL present the head word on data_out at the next rising edge (1-cycle latency); otherwise data_out SHALL hold its value.
REQ-016 In FIFO_FWFT, data_out SHALL show the head word whenever !empty (0-cycle read latency), a written word SHALL appear on data_out one cycle after the write into an empty FIFO, and data_out SHALL hold its last value when empty.
REQ-017 overflow SHALL set on write_enable=1 with the write rejected, and SHALL stay set until clear_errors=1 or reset.
REQ-018 underflow SHALL set on read_enable=1 with the read rejected, and SHALL stay set until clear_errors=1 or reset.
REQ-019 When clear_errors coincides with a new error event, the flag SHALL remain set (set wins).
REQ-020 Rejected operations SHALL not alter pointers, count, storage or data_out.

Reset
REQ-021 While resetn=0: pointers=0, count=0, data_out=0, overflow=0, underflow=0, hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
REQ-022 Reset mid-operation SHALL discard all contents immediately; storage array contents need not be cleared.
REQ-023 Operation SHALL resume on the first rising edge after resetn deasserts.

Structure
REQ-024 Package fifo_pkg SHALL hold enum fifo_mode_t {FIFO_STD, FIFO_FWFT} and a count-width helper function.
REQ-025 Storage SHALL be a sub-module fifo_mem (WIDTH x DEPTH, one write port, one asynchronous read port), without reset.
REQ-026 Parameter legality (DEPTH>=2, threshold ranges) SHALL be checked at elaboration with a fatal error.

Verification
REQ-027 STD, DEPTH=4: write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1 after 3rd; 5th write 0x55 -> overflow=1, contents unchanged.
REQ-028 STD: full, then read+write 0x66 same cycle -> both accepted, count=4, data_out=0x11 next cycle, later reads 0x22,0x33,0x44,0x66.
REQ-029 STD: empty, read+write 0x77 same cycle -> underflow=1, count=1, data_out unchanged; clear_errors -> underflow=0.
REQ-030 FWFT: write 0xA5 into empty -> data_out=0xA5 next cycle, empty=0; read -> empty=1, data_out holds 0xA5.
REQ-031 Write 6 / read 6 interleaved twice (pointer wrap) -> data order preserved; resetn pulse with count=3 -> empty=1, count=0, data_out=0, flags=0.
REQ-032 Random traffic against a behavioural queue model, compared every cycle with !== on all outputs, for both MODE values and DEPTH in {2,3,4,8}.
